// File: rtl/calc_disp_pkg.sv
// calc_disp_pkg: shared constants and helpers for the calculator display path.
package calc_disp_pkg;
  localparam int NIBBLE_W = 4;
  localparam int MAX_DIGITS = 8;
  localparam int DEF_SCAN_DIV = 50000;
  localparam int DEF_DEAD_CYCLES = 2;
  function automatic logic [MAX_DIGITS-1:0] onehot(input logic [2:0] i);
    return MAX_DIGITS'(1) << i;
  endfunction
endpackage

// File: rtl/scan_prescaler.sv
// scan_prescaler: divides clk into digit slots; flags slot end, frame end and the dead zone.
module scan_prescaler
  import calc_disp_pkg::*;
#(
  parameter int SCAN_DIV = DEF_SCAN_DIV,
  parameter int DEAD_CYCLES = DEF_DEAD_CYCLES
) (
  input  logic clk,
  input  logic rst_n,
  input  logic last_slot,
  output logic tick,
  output logic boundary,
  output logic dead
);
  localparam int CW = $clog2(SCAN_DIV);
  logic [CW-1:0] cnt;
  assign tick = cnt == CW'(SCAN_DIV - 1);
  assign boundary = tick && last_slot;
  assign dead = cnt < CW'(DEAD_CYCLES);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cnt <= '0;
    else cnt <= tick ? '0 : cnt + 1'b1;
endmodule

// File: rtl/display_scan_ctrl.sv
// display_scan_ctrl: multiplexed 7-segment scanner with frame-synchronous value
// updates, leading-zero blanking and per-slot dead time; digitBin feeds the decoder.
module display_scan_ctrl
  import calc_disp_pkg::*;
#(
  parameter int NUM_DIGITS = 4,
  parameter int SCAN_DIV = DEF_SCAN_DIV,
  parameter int DEAD_CYCLES = DEF_DEAD_CYCLES
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic [NIBBLE_W*NUM_DIGITS-1:0] value,
  input  logic                           load,
  input  logic                           blank_lz,
  output logic [NIBBLE_W-1:0]            digitBin,
  output logic [NUM_DIGITS-1:0]          digitEn,
  output logic                           frame_done
);
  localparam int IW = NUM_DIGITS > 1 ? $clog2(NUM_DIGITS) : 1;
  localparam int VW = NIBBLE_W * NUM_DIGITS;
  logic [IW-1:0] idx;
  logic [VW-1:0] pending, shadow;
  logic pend_flag, tick, boundary, dead, last_slot, blanked;
  logic [NUM_DIGITS:0] zero_from;
  logic [NIBBLE_W-1:0] nib;
  logic [MAX_DIGITS-1:0] oh;
  assign last_slot = idx == IW'(NUM_DIGITS - 1);
  assign nib = shadow[NIBBLE_W*idx +: NIBBLE_W];
  assign oh = onehot(3'(idx));
  scan_prescaler #(.SCAN_DIV(SCAN_DIV), .DEAD_CYCLES(DEAD_CYCLES)) u_pre (
    .clk(clk), .rst_n(rst_n), .last_slot(last_slot),
    .tick(tick), .boundary(boundary), .dead(dead)
  );
  // zero_from[i]: every nibble from slot i upward is zero
  always_comb begin
    zero_from = '0;
    zero_from[NUM_DIGITS] = 1'b1;
    for (int i = NUM_DIGITS - 1; i >= 0; i--)
      zero_from[i] = zero_from[i+1] && shadow[NIBBLE_W*i +: NIBBLE_W] == '0;
  end
  assign blanked = blank_lz && idx != '0 && zero_from[idx];
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      idx <= '0;
      pending <= '0;
      pend_flag <= 1'b0;
      shadow <= '0;
      digitBin <= '0;
      digitEn <= '0;
      frame_done <= 1'b0;
    end else begin
      if (tick) idx <= last_slot ? '0 : idx + 1'b1;
      if (load) begin
        pending <= value;
        pend_flag <= 1'b1;
      end
      // a load on the boundary itself bypasses the pending buffer
      if (boundary) begin
        shadow <= load ? value : pend_flag ? pending : shadow;
        pend_flag <= 1'b0;
      end
      frame_done <= boundary;
      digitBin <= blanked ? '0 : nib;
      digitEn <= (dead || blanked) ? '0 : oh[NUM_DIGITS-1:0];
    end
endmodule

// File: tb/tb_display_scan_ctrl.sv
// tb_display_scan_ctrl: directed scenarios plus random loads/blanking checked against
// a time-arithmetic reference model of the scanner.
module tb_display_scan_ctrl;
  localparam int N = 4, SD = 8, DC = 2, FR = SD * N;
  logic clk = 0, rst_n = 1, load = 0, blank_lz = 0;
  logic [15:0] value = 0;
  logic [3:0] digitBin, digitEn;
  logic frame_done;
  int tests = 0, fails = 0, t = 0;
  logic [15:0] m_shadow = 0, m_pend = 0;
  bit m_pflag = 0;

  always #5 clk = ~clk;

  display_scan_ctrl #(.NUM_DIGITS(N), .SCAN_DIV(SD), .DEAD_CYCLES(DC)) dut (
    .clk(clk), .rst_n(rst_n), .value(value), .load(load), .blank_lz(blank_lz),
    .digitBin(digitBin), .digitEn(digitEn), .frame_done(frame_done)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s at t=%0d: got %0h expected %0h", tag, t, got, exp);
    end
  endtask

  // one clock: predict outputs from the model, advance the model, check after the edge
  task automatic cyc();
    logic [3:0] eb, ee;
    logic ef;
    int ph, sl;
    bit bl;
    if (!rst_n) begin
      eb = 0; ee = 0; ef = 0;
      t = 0; m_shadow = 0; m_pend = 0; m_pflag = 0;
    end else begin
      ph = t % SD;
      sl = (t / SD) % N;
      bl = blank_lz && sl > 0 && (m_shadow >> (4 * sl)) == 0;
      eb = bl ? 4'h0 : 4'((m_shadow >> (4 * sl)) & 16'hF);
      ee = (ph >= DC && !bl) ? 4'(1 << sl) : 4'h0;
      ef = (t % FR) == FR - 1;
      if (ef) begin
        m_shadow = load ? value : (m_pflag ? m_pend : m_shadow);
        m_pflag = 0;
      end else if (load) begin
        m_pend = value;
        m_pflag = 1;
      end
      t++;
    end
    @(posedge clk);
    @(negedge clk);
    chk("digitBin", 32'(digitBin), 32'(eb));
    chk("digitEn", 32'(digitEn), 32'(ee));
    chk("frame_done", 32'(frame_done), 32'(ef));
    chk("en_onehot0", 32'($countones(digitEn) <= 1), 32'd1);
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cyc();
  endtask

  task automatic run_to(input int p);
    for (int i = 0; i < FR && (t % FR) != p; i++) cyc();
  endtask

  task automatic pulse_load(input logic [15:0] v);
    value = v;
    load = 1;
    cyc();
    load = 0;
  endtask

  initial begin
    #1 rst_n = 0;
    @(negedge clk);
    run(2);
    rst_n = 1;
    run(FR);
    run_to(10);
    pulse_load(16'h1234);
    run(2 * FR);
    blank_lz = 1;
    pulse_load(16'h0050);
    run(2 * FR);
    pulse_load(16'h0000);
    run(2 * FR);
    blank_lz = 0;
    run_to(3);
    pulse_load(16'hAAAA);
    run(5);
    pulse_load(16'h0BCD);
    run(2 * FR);
    run_to(FR - 1);
    pulse_load(16'h9876);
    run(2 * FR);
    run_to(18);
    pulse_load(16'h5A5A);
    run(1);
    #2 rst_n = 0;
    #1;
    chk("rst_async_bin", 32'(digitBin), 0);
    chk("rst_async_en", 32'(digitEn), 0);
    chk("rst_async_fd", 32'(frame_done), 0);
    @(negedge clk);
    run(2);
    rst_n = 1;
    run(2 * FR);
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 49) == 0) blank_lz = ~blank_lz;
      if ($urandom_range(0, 9) == 0) begin
        value = 16'($urandom) & (16'hFFFF >> (4 * $urandom_range(0, 3)));
        load = 1;
      end else load = 0;
      cyc();
    end
    load = 0;
    run(FR);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/display_scan_ctrl.md
Name: display_scan_ctrl

Overview:
Time-multiplexed scanner for the calculator's multi-digit 7-segment display. It sits directly upstream of the binary-to-7-segment decoder. It holds the displayed value, walks one digit slot at a time at a divided rate, and presents the active nibble to the decoder together with a one-hot digit enable. Value updates are double-buffered to frame boundaries, which prevents tearing. The block also provides leading-zero blanking and a dead time per slot for anti-ghosting.

Parameters:
NUM_DIGITS, 4, number of digit slots; legal range 1..8.
SCAN_DIV, 50000, clock cycles per digit slot; must be at least 2.
DEAD_CYCLES, 2, cycles at the start of each slot with all enables off; must be less than SCAN_DIV.

Ports:
clk  in  1  system clock; the block has one clock.
rst_n  in  1  reset, asynchronous, active-low.
value  in  4*NUM_DIGITS  value to display; nibble i drives digit i, and digit 0 is the rightmost.
load  in  1  single-cycle strobe that captures value.
blank_lz  in  1  when 1, leading-zero blanking is enabled.
digitBin  out  4  nibble for the active slot; feeds the decoder's bin input.
digitEn  out  NUM_DIGITS  one-hot, active-high digit enable.
frame_done  out  1  one-cycle pulse after each complete scan frame.

Behaviour:
- State:
  - cnt: 0..SCAN_DIV-1
  - idx: 0..NUM_DIGITS-1
  - pending register and pend_flag
  - shadow register, which holds the value currently displayed
- Reset (asynchronous on rst_n low, held while low):
  - cnt=0, idx=0, pending=0, pend_flag=0, shadow=0
  - digitBin=0, digitEn=0, frame_done=0
  - Reset mid-frame aborts the frame. Any pending value is discarded.
- Counter and slot advance:
  - cnt increments every cycle.
  - tick = (cnt==SCAN_DIV-1). On tick, cnt returns to 0 and idx advances, wrapping from NUM_DIGITS-1 to 0.
  - The wrap tick is the frame boundary.
- Load:
  - When load=1: pending<=value and pend_flag<=1.
  - Several loads within one frame: the last one wins.
- Frame boundary:
  - If load=1 on the same cycle as the boundary, shadow<=value directly (bypass path).
  - Otherwise, if pend_flag=1, shadow<=pending.
  - In both cases pend_flag<=0.
  - frame_done=1 for exactly the one cycle following the boundary edge.
- Outputs are registered with 1-cycle latency. Each output at edge t+1 is a function of (cnt, idx, shadow, blank_lz) at cycle t:
  - digitBin = shadow[4*idx +: 4], or 0 if the slot is blanked.
  - digitEn = one-hot(idx) if cnt>=DEAD_CYCLES and the slot is not blanked; otherwise all zeros.
- Blanking rule:
  - Slot i (i>0) is blanked when blank_lz=1 and every nibble from i up to NUM_DIGITS-1 is zero.
  - Slot 0 is never blanked, so value 0 displays "0".
  - blank_lz is sampled live; it is not double-buffered.
- Invariants:
  - digitEn is never multi-hot.
  - digitEn is 0 for at least DEAD_CYCLES cycles between consecutive slots.
- NUM_DIGITS=1: idx stays at 0 and every tick is a frame boundary.

Decomposition:
- Shared package (calc_disp_pkg):
  - NIBBLE_W=4
  - constants for default SCAN_DIV and DEAD_CYCLES
  - a function for one-hot decode of the index
- One natural sub-module: scan_prescaler. It holds the cnt counter and produces tick, the wrap/boundary flag and a dead-zone flag.
- Blanking logic and the buffer registers stay inline.
- Top-level integration instantiates this block and connects digitBin to the decoder's bin input.

Test Plan:
Bench parameters for all scenarios: NUM_DIGITS=4, SCAN_DIV=8, DEAD_CYCLES=2.
1. Release rst_n with value=0 -> digitEn=0 on edges 1-2, digitEn=4'b0001 with digitBin=0 from edge 3. Slots 1-3 are enabled with digitBin=0 when blank_lz=0.
2. Pulse load with 16'h1234 mid-frame -> the current frame is unchanged. From the next frame, slots 0..3 show digitBin 4,3,2,1, and frame_done pulses every 32 cycles.
3. Set blank_lz=1 and load 16'h0050 -> digitEn bits 3 and 2 are never asserted, slot 1 shows 5, slot 0 shows 0. Then load 16'h0000 -> only slot 0 is enabled.
4. Load 16'hAAAA then 16'h0BCD in the same frame -> the next frame shows D,C,B,0, and 16'hAAAA never appears.
5. Assert load with 16'h9876 on the exact boundary cycle -> slot 0 of the new frame shows 6. pend_flag is 0 afterwards.
6. Drop rst_n mid-slot 2 with a pending load -> all outputs go to 0 immediately. After release, the display shows 0, not the pending value.
